// File: rtl/gmux_hsck_ctrl.sv
// gmux_hsck_ctrl
//   Sequencer for the quadrant enable pins of the high-speed global clock mux
//   (GMUX_HSCK). It accepts enable / disable / enter-VLP / exit-VLP commands
//   and applies timed sequences so that every quadrant enters or leaves the
//   static configuration (SSEL=1, SEN=1, DEN=0, VLP=0) without runt pulses.
//
// Ports
//   CLK        sequencer clock
//   RST        asynchronous reset, active-high
//   CMD_VALID  command valid
//   CMD_READY  sequencer can accept a command (IDLE only, low during reset)
//   CMD_OP     00=enable, 01=disable, 10=enter VLP, 11=exit VLP
//   CMD_QMASK  quadrant select, bit0=TL bit1=TR bit2=BL bit3=BR
//   SSEL       static select to the mux
//   SEN        static enable per quadrant
//   DEN        dynamic enable per quadrant
//   DYNEN      dynamic-path select per quadrant
//   VLP        very-low-power per quadrant
//   DONE       one-cycle pulse when a command completes
//   ERR        one-cycle pulse when a command is rejected
//   BUSY       high whenever the sequencer is not IDLE
//   STATE_DBG  current FSM state encoding (observation only)
//
// Handshake: a command transfers on the rising CLK edge where
// CMD_VALID && CMD_READY. CMD_READY is driven only from the FSM state (and
// reset), never from CMD_VALID. A requester keeps CMD_VALID and its payload
// stable until the transfer; while BUSY the request is simply left pending.

module gmux_hsck_ctrl #(
  parameter int SETTLE_CYC = 4,
  parameter int DRAIN_CYC  = 2,
  parameter int WAKE_CYC   = 8,
  parameter int CNT_W      = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [1:0]       CMD_OP,
  input  logic [3:0]       CMD_QMASK,
  output logic             SSEL,
  output logic [3:0]       SEN,
  output logic [3:0]       DEN,
  output logic [3:0]       DYNEN,
  output logic [3:0]       VLP,
  output logic             DONE,
  output logic             ERR,
  output logic             BUSY,
  output logic [2:0]       STATE_DBG
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_EN_DYN    = 3'd1,
    S_EN_COMMIT = 3'd2,
    S_DIS_DRAIN = 3'd3,
    S_VLP_SET   = 3'd4,
    S_VLP_WAKE  = 3'd5,
    S_FINISH    = 3'd6
  } state_t;

  localparam logic [1:0] OP_EN      = 2'b00;
  localparam logic [1:0] OP_DIS     = 2'b01;
  localparam logic [1:0] OP_VLP_ON  = 2'b10;
  localparam logic [1:0] OP_VLP_OFF = 2'b11;

  // Wait counters are loaded with N-1 and the exit is taken on the cycle the
  // counter reads zero, so a wait of N gives exactly N cycles in the state.
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] DRAIN_LD  = CNT_W'(DRAIN_CYC - 1);
  localparam logic [CNT_W-1:0] WAKE_LD   = CNT_W'(WAKE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

  state_t           state, nxt_state;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  logic [3:0]       mask, nxt_mask;
  logic             nxt_ssel;
  logic [3:0]       nxt_sen, nxt_den, nxt_dynen, nxt_vlp;
  logic             nxt_done, nxt_err;
  logic             accept;

  assign CMD_READY = (state == S_IDLE) && !RST;
  assign BUSY      = (state != S_IDLE);
  assign STATE_DBG = state;
  assign accept    = CMD_VALID && CMD_READY;

  // State and output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= S_IDLE;
      cnt   <= CNT_ZERO;
      mask  <= 4'h0;
      SSEL  <= 1'b0;
      SEN   <= 4'h0;
      DEN   <= 4'h0;
      DYNEN <= 4'h0;
      VLP   <= 4'hF;
      DONE  <= 1'b0;
      ERR   <= 1'b0;
    end else begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
      mask  <= nxt_mask;
      SSEL  <= nxt_ssel;
      SEN   <= nxt_sen;
      DEN   <= nxt_den;
      DYNEN <= nxt_dynen;
      VLP   <= nxt_vlp;
      DONE  <= nxt_done;
      ERR   <= nxt_err;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_mask  = mask;
    nxt_ssel  = SSEL;
    nxt_sen   = SEN;
    nxt_den   = DEN;
    nxt_dynen = DYNEN;
    nxt_vlp   = VLP;
    nxt_done  = 1'b0;
    nxt_err   = 1'b0;

    case (state)
      S_IDLE: begin
        if (accept) begin
          nxt_mask = CMD_QMASK;
          if (CMD_QMASK == 4'h0) begin
            // Empty mask: nothing to sequence, report completion directly.
            nxt_done = 1'b1;
          end else begin
            case (CMD_OP)
              OP_EN: begin
                if ((CMD_QMASK & VLP) != 4'h0) begin
                  nxt_err = 1'b1;
                end else begin
                  // Quadrants already statically enabled keep SEN and do not
                  // get DEN, so SEN and DEN are never high together.
                  nxt_den   = DEN   | (CMD_QMASK & ~SEN);
                  nxt_dynen = DYNEN | (CMD_QMASK & ~SEN);
                  nxt_cnt   = SETTLE_LD;
                  nxt_state = S_EN_DYN;
                end
              end
              OP_DIS: begin
                nxt_sen   = SEN   & ~CMD_QMASK;
                nxt_den   = DEN   & ~CMD_QMASK;
                nxt_dynen = DYNEN & ~CMD_QMASK;
                nxt_cnt   = DRAIN_LD;
                nxt_state = S_DIS_DRAIN;
              end
              OP_VLP_ON: begin
                if ((CMD_QMASK & (SEN | DEN)) != 4'h0) begin
                  nxt_err = 1'b1;
                end else begin
                  nxt_vlp   = VLP | CMD_QMASK;
                  nxt_state = S_VLP_SET;
                end
              end
              OP_VLP_OFF: begin
                nxt_vlp   = VLP & ~CMD_QMASK;
                nxt_cnt   = WAKE_LD;
                nxt_state = S_VLP_WAKE;
              end
            endcase
          end
        end
      end

      S_EN_DYN: begin
        if (cnt != CNT_ZERO) begin
          nxt_cnt = cnt - CNT_ONE;
        end else begin
          // Hand over from the dynamic path to static enable on one edge.
          nxt_sen   = SEN   | mask;
          nxt_den   = DEN   & ~mask;
          nxt_dynen = DYNEN & ~mask;
          nxt_ssel  = 1'b1;
          nxt_state = S_EN_COMMIT;
        end
      end

      S_EN_COMMIT: begin
        nxt_state = S_FINISH;
      end

      S_DIS_DRAIN: begin
        if (cnt != CNT_ZERO) begin
          nxt_cnt = cnt - CNT_ONE;
        end else begin
          // Static select is released only once no quadrant uses it.
          if (SEN == 4'h0) nxt_ssel = 1'b0;
          nxt_state = S_FINISH;
        end
      end

      S_VLP_SET: begin
        nxt_state = S_FINISH;
      end

      S_VLP_WAKE: begin
        if (cnt != CNT_ZERO) begin
          nxt_cnt = cnt - CNT_ONE;
        end else begin
          nxt_state = S_FINISH;
        end
      end

      S_FINISH: begin
        nxt_done  = 1'b1;
        nxt_state = S_IDLE;
      end

      default: begin
        nxt_state = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_gmux_hsck_ctrl.sv
// tb_gmux_hsck_ctrl
//   Directed bench for gmux_hsck_ctrl with default parameters
//   (SETTLE_CYC=4, DRAIN_CYC=2, WAKE_CYC=8). Inputs change and outputs are
//   sampled on the falling clock edge. Index k in the history arrays is the
//   falling edge that follows the k-th rising edge after the accept edge
//   (k=0 is the half-cycle right after accept).

module tb_gmux_hsck_ctrl;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_qmask;
  logic       ssel;
  logic [3:0] sen, den, dynen, vlp;
  logic       done, err, busy;
  logic [2:0] state_dbg;

  int checks;
  int errors;

  logic [3:0] sen_h   [0:31];
  logic [3:0] den_h   [0:31];
  logic [3:0] dynen_h [0:31];
  logic [3:0] vlp_h   [0:31];
  logic       ssel_h  [0:31];
  logic       done_h  [0:31];
  logic       err_h   [0:31];
  logic       busy_h  [0:31];
  logic       ready_h [0:31];

  gmux_hsck_ctrl dut (
    .CLK       (clk),
    .RST       (rst),
    .CMD_VALID (cmd_valid),
    .CMD_READY (cmd_ready),
    .CMD_OP    (cmd_op),
    .CMD_QMASK (cmd_qmask),
    .SSEL      (ssel),
    .SEN       (sen),
    .DEN       (den),
    .DYNEN     (dynen),
    .VLP       (vlp),
    .DONE      (done),
    .ERR       (err),
    .BUSY      (busy),
    .STATE_DBG (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // Presents a command at a falling edge, waits (bounded) for ready, lets
  // the accept edge pass and returns at falling edge k=0.
  task automatic issue(input logic [1:0] op, input logic [3:0] qm, output bit ok);
    ok        = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_qmask = qm;
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic record(input int n);
    for (int k = 0; k < n; k++) begin
      sen_h[k]   = sen;
      den_h[k]   = den;
      dynen_h[k] = dynen;
      vlp_h[k]   = vlp;
      ssel_h[k]  = ssel;
      done_h[k]  = done;
      err_h[k]   = err;
      busy_h[k]  = busy;
      ready_h[k] = cmd_ready;
      @(negedge clk);
    end
  endtask

  task automatic issue_checked(input logic [1:0] op, input logic [3:0] qm, input string name);
    bit ok;
    issue(op, qm, ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL %s_accept: got ready=%0b within budget expected 1", name, ok);
    end
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ({sen, den, dynen} !== 12'h000) begin
      errors++;
      $display("FAIL reset_en: got sen=%h den=%h dynen=%h expected 0 0 0", sen, den, dynen);
    end
    checks++;
    if (vlp !== 4'hF || ssel !== 1'b0) begin
      errors++;
      $display("FAIL reset_vlp_ssel: got vlp=%h ssel=%b expected F 0", vlp, ssel);
    end
    checks++;
    if ({done, err, busy, cmd_ready} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got done=%b err=%b busy=%b ready=%b expected 0 0 0 0",
               done, err, busy, cmd_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_release: got %b expected 1", cmd_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_qmask_zero();
    for (int op = 0; op < 4; op++) begin
      issue_checked(2'(op), 4'h0, "qzero");
      record(3);
      checks++;
      if (done_h[0] !== 1'b1 || done_h[1] !== 1'b0) begin
        errors++;
        $display("FAIL qzero_done op%0d: got k0=%b k1=%b expected 1 0", op, done_h[0], done_h[1]);
      end
      checks++;
      if (err_h[0] !== 1'b0 || busy_h[0] !== 1'b0) begin
        errors++;
        $display("FAIL qzero_err_busy op%0d: got err=%b busy=%b expected 0 0", op, err_h[0], busy_h[0]);
      end
      checks++;
      if ({sen_h[1], den_h[1], dynen_h[1], vlp_h[1], 3'b000, ssel_h[1]} !== 20'h000F0) begin
        errors++;
        $display("FAIL qzero_outputs op%0d: got sen=%h den=%h dynen=%h vlp=%h ssel=%b expected 0 0 0 F 0",
                 op, sen_h[1], den_h[1], dynen_h[1], vlp_h[1], ssel_h[1]);
      end
    end
  endtask

  task automatic test_exit_vlp();
    int lat, nbusy, ndone;
    issue_checked(2'b11, 4'h1, "exit_vlp");
    record(12);
    lat = -1; nbusy = 0; ndone = 0;
    for (int k = 0; k < 12; k++) begin
      if (done_h[k] && lat < 0) lat = k;
      if (busy_h[k]) nbusy++;
      if (done_h[k]) ndone++;
    end
    checks++;
    if (vlp_h[0] !== 4'hE) begin
      errors++;
      $display("FAIL exit_vlp_value: got %h expected E", vlp_h[0]);
    end
    checks++;
    if (lat !== 9 || ndone !== 1) begin
      errors++;
      $display("FAIL exit_vlp_latency: got lat=%0d pulses=%0d expected 9 1", lat, ndone);
    end
    checks++;
    if (nbusy !== 9) begin
      errors++;
      $display("FAIL exit_vlp_busy: got %0d cycles expected 9", nbusy);
    end
  endtask

  task automatic test_enable();
    int lat, nden, overlap;
    issue_checked(2'b00, 4'h1, "enable");
    record(10);
    lat = -1; nden = 0; overlap = 0;
    for (int k = 0; k < 10; k++) begin
      if (done_h[k] && lat < 0) lat = k;
      if (den_h[k][0] && dynen_h[k][0]) nden++;
      if ((sen_h[k] & den_h[k]) != 4'h0) overlap++;
      if ((vlp_h[k] & (sen_h[k] | den_h[k])) != 4'h0) overlap++;
    end
    checks++;
    if (nden !== 4) begin
      errors++;
      $display("FAIL enable_dyn_cycles: got %0d expected 4", nden);
    end
    checks++;
    if (sen_h[3] !== 4'h0 || den_h[3] !== 4'h1 || ssel_h[3] !== 1'b0) begin
      errors++;
      $display("FAIL enable_pre_commit: got sen=%h den=%h ssel=%b expected 0 1 0",
               sen_h[3], den_h[3], ssel_h[3]);
    end
    checks++;
    if (sen_h[4] !== 4'h1 || den_h[4] !== 4'h0 || dynen_h[4] !== 4'h0 || ssel_h[4] !== 1'b1) begin
      errors++;
      $display("FAIL enable_commit: got sen=%h den=%h dynen=%h ssel=%b expected 1 0 0 1",
               sen_h[4], den_h[4], dynen_h[4], ssel_h[4]);
    end
    checks++;
    if (lat !== 6) begin
      errors++;
      $display("FAIL enable_latency: got %0d expected 6", lat);
    end
    checks++;
    if (overlap !== 0) begin
      errors++;
      $display("FAIL enable_invariant: got %0d bad cycles expected 0", overlap);
    end
  endtask

  task automatic test_enable_err();
    int nerr, ndone;
    issue_checked(2'b00, 4'h2, "enable_err");
    record(4);
    nerr = 0; ndone = 0;
    for (int k = 0; k < 4; k++) begin
      if (err_h[k]) nerr++;
      if (done_h[k]) ndone++;
    end
    checks++;
    if (err_h[0] !== 1'b1 || nerr !== 1 || ndone !== 0) begin
      errors++;
      $display("FAIL enable_err_pulse: got k0=%b pulses=%0d done=%0d expected 1 1 0", err_h[0], nerr, ndone);
    end
    checks++;
    if (sen_h[0] !== 4'h1 || den_h[0] !== 4'h0 || vlp_h[0] !== 4'hE || ssel_h[0] !== 1'b1) begin
      errors++;
      $display("FAIL enable_err_outputs: got sen=%h den=%h vlp=%h ssel=%b expected 1 0 E 1",
               sen_h[0], den_h[0], vlp_h[0], ssel_h[0]);
    end
    checks++;
    if (ready_h[1] !== 1'b1 || busy_h[0] !== 1'b0) begin
      errors++;
      $display("FAIL enable_err_ready: got ready=%b busy=%b expected 1 0", ready_h[1], busy_h[0]);
    end
  endtask

  task automatic test_disable_then_vlp();
    int lat;
    issue_checked(2'b01, 4'h1, "disable");
    record(6);
    lat = -1;
    for (int k = 0; k < 6; k++) if (done_h[k] && lat < 0) lat = k;
    checks++;
    if (sen_h[0] !== 4'h0 || den_h[0] !== 4'h0) begin
      errors++;
      $display("FAIL disable_sen: got sen=%h den=%h expected 0 0", sen_h[0], den_h[0]);
    end
    checks++;
    if (ssel_h[1] !== 1'b1 || ssel_h[2] !== 1'b0) begin
      errors++;
      $display("FAIL disable_ssel: got k1=%b k2=%b expected 1 0", ssel_h[1], ssel_h[2]);
    end
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL disable_latency: got %0d expected 3", lat);
    end
    issue_checked(2'b10, 4'h1, "enter_vlp");
    record(5);
    lat = -1;
    for (int k = 0; k < 5; k++) if (done_h[k] && lat < 0) lat = k;
    checks++;
    if (vlp_h[4] !== 4'hF || err_h[0] !== 1'b0) begin
      errors++;
      $display("FAIL enter_vlp_value: got vlp=%h err=%b expected F 0", vlp_h[4], err_h[0]);
    end
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL enter_vlp_latency: got %0d expected 2", lat);
    end
  endtask

  task automatic test_rst_mid_command();
    int ndone;
    issue_checked(2'b11, 4'h4, "rst_wake");
    record(12);
    checks++;
    if (vlp !== 4'hB) begin
      errors++;
      $display("FAIL rst_pre_wake: got vlp=%h expected B", vlp);
    end
    issue_checked(2'b00, 4'h4, "rst_enable");
    @(negedge clk);
    checks++;
    if (den !== 4'h4 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_in_dyn: got den=%h busy=%b expected 4 1", den, busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (den !== 4'h0 || dynen !== 4'h0 || vlp !== 4'hF || ssel !== 1'b0 || sen !== 4'h0) begin
      errors++;
      $display("FAIL rst_async_outputs: got sen=%h den=%h dynen=%h vlp=%h ssel=%b expected 0 0 0 F 0",
               sen, den, dynen, vlp, ssel);
    end
    checks++;
    if (busy !== 1'b0 || cmd_ready !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rst_async_flags: got busy=%b ready=%b done=%b expected 0 0 0", busy, cmd_ready, done);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_ready_after: got %b expected 1", cmd_ready);
    end
    @(negedge clk);
    record(10);
    ndone = 0;
    for (int k = 0; k < 10; k++) if (done_h[k]) ndone++;
    checks++;
    if (ndone !== 0) begin
      errors++;
      $display("FAIL rst_no_done: got %0d pulses expected 0", ndone);
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_qmask = 4'h0;

    test_reset();
    test_qmask_zero();
    test_exit_vlp();
    test_enable();
    test_enable_err();
    test_disable_then_vlp();
    test_rst_mid_command();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
